rs_syndrome_seq: RTL and testbench

- Sequences a bank of GF(2^8) constant multipliers, one per syndrome, to compute the 2T Reed-Solomon syndromes of each received codeword by Horner's rule.
- Field: p(x) = x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02, polynomial-basis symbols.
- Sits between the symbol deframer and the key-equation solver.
- Owns frame counting, accumulator sequencing, output hold/backpressure and framing-error detection.

---
 rtl/rs_pkg.sv | 42 ++++
 rtl/rs_syn_cell.sv | 32 +++
 rtl/rs_syndrome_seq.sv | 128 ++++++++++++
 tb/tb_rs_syndrome_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// GF(2^8) helpers and sequencer state encoding shared by the syndrome
// sequencer and its per-syndrome cells.
package rs_pkg;

  localparam int         GF_M    = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_t;

  // Multiply by alpha (x) with reduction modulo the field polynomial.
  function automatic logic [GF_M-1:0] gf_xtime(input logic [GF_M-1:0] a);
    gf_xtime = {a[GF_M-2:0], 1'b0} ^ (a[GF_M-1] ? GF_POLY[GF_M-1:0] : '0);
  endfunction

  // alpha^k, evaluated at elaboration for constant roots.
  function automatic logic [GF_M-1:0] gf_pow(input int k);
    logic [GF_M-1:0] r;
    r = 8'h01;
    for (int i = 0; i < (k % 255); i++) r = gf_xtime(r);
    return r;
  endfunction

  // Constant times variable: with a constant first operand this folds into
  // a fixed 8x8 XOR matrix applied to x.
  function automatic logic [GF_M-1:0] gf_cmul(input logic [GF_M-1:0] c,
                                              input logic [GF_M-1:0] x);
    logic [GF_M-1:0] acc;
    logic [GF_M-1:0] sh;
    acc = '0;
    sh  = x;
    for (int i = 0; i < GF_M; i++) begin
      if (c[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_syn_cell.sv
// One syndrome accumulator: Horner step S <= S*alpha^ROOT ^ sym, or a
// fresh load of the first symbol of a frame.
module rs_syn_cell
  import rs_pkg::*;
#(
  parameter int ROOT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [GF_M-1:0] sym,
  output logic [GF_M-1:0] s,
  output logic [GF_M-1:0] s_next
);

  localparam logic [GF_M-1:0] ROOT_VAL = gf_pow(ROOT);

  // Next accumulator value; exposed so the parent can flag all-zero early.
  always_comb begin
    s_next = s;
    if (load)    s_next = sym;
    else if (en) s_next = gf_cmul(ROOT_VAL, s) ^ sym;
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s <= '0;
    else     s <= s_next;
  end

endmodule

// File: rtl/rs_syndrome_seq.sv
// Reed-Solomon syndrome sequencer: frames incoming symbols, drives a bank of
// Horner accumulators and holds the finished syndrome vector for handoff.
module rs_syndrome_seq
  import rs_pkg::*;
#(
  parameter int N     = 255,
  parameter int TWO_T = 16,
  parameter int FCR   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_sym,
  input  logic               in_sop,
  output logic               syn_valid,
  input  logic               syn_ready,
  output logic [8*TWO_T-1:0] syn_data,
  output logic               syn_zero,
  output logic               frame_err
);

  localparam int               CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  seq_state_t         state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               load, en, err_next, finish, accept;
  logic [8*TWO_T-1:0] s_next_all;

  assign accept = in_valid & in_ready;
  assign finish = en && (cnt == LAST_CNT);

  genvar j;
  generate
    for (j = 0; j < TWO_T; j++) begin : g_cell
      rs_syn_cell #(.ROOT(FCR + j)) u_cell (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .en     (en),
        .sym    (in_sym),
        .s      (syn_data[8*j +: 8]),
        .s_next (s_next_all[8*j +: 8])
      );
    end
  endgenerate

  // Next-state, counter and accumulator control; HOLD forwards syn_ready to
  // in_ready so a new frame can start in the handshake cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    en         = 1'b0;
    err_next   = 1'b0;
    in_ready   = 1'b1;
    syn_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (in_sop) begin
            load       = 1'b1;
            cnt_next   = CNT_W'(1);
            state_next = ST_ACC;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_ACC: begin
        if (accept) begin
          if (in_sop) begin
            err_next = 1'b1;
            load     = 1'b1;
            cnt_next = CNT_W'(1);
          end else begin
            en       = 1'b1;
            cnt_next = cnt + CNT_W'(1);
            if (cnt == LAST_CNT) state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        in_ready  = syn_ready;
        syn_valid = 1'b1;
        if (syn_ready) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          if (accept) begin
            if (in_sop) begin
              load       = 1'b1;
              cnt_next   = CNT_W'(1);
              state_next = ST_ACC;
            end else begin
              err_next = 1'b1;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and symbol counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // All-zero flag captured with the final accumulator update, plus the
  // one-cycle framing error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syn_zero  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_next;
      if (finish) syn_zero <= ~|s_next_all;
    end
  end

endmodule

// File: tb/tb_rs_syndrome_seq.sv
// Randomized scoreboard bench for rs_syndrome_seq: expected syndromes come
// from direct polynomial evaluation over GF(2^8) log/antilog tables.
module tb_rs_syndrome_seq;

  localparam int N     = 255;
  localparam int TWO_T = 16;
  localparam int FCR   = 0;
  localparam int SW    = 8 * TWO_T;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          syn_ready = 1'b1;
  logic [7:0]    in_sym = 8'h00;
  logic          in_ready, syn_valid, syn_zero, frame_err;
  logic [SW-1:0] syn_data;

  int            n_checks = 0;
  int            n_pass = 0;
  int            err_seen = 0;
  int            err_exp = 0;
  int            last_wait = 0;
  int            first_wait = 0;
  logic          first_err = 1'b0;
  logic [SW:0]   exp_q[$];
  logic [SW:0]   mon_exp;
  logic [7:0]    frm[0:N-1];
  int            exp_t[0:255];
  int            log_t[0:255];

  localparam logic [SW-1:0] ALPHA_VEC = {8'h26, 8'h13, 8'h87, 8'hCD, 8'hE8, 8'h74, 8'h3A, 8'h1D,
                                         8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  always #5 clk = ~clk;

  rs_syndrome_seq #(.N(N), .TWO_T(TWO_T), .FCR(FCR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_sop    (in_sop),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn_data  (syn_data),
    .syn_zero  (syn_zero),
    .frame_err (frame_err)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
  endfunction

  function automatic logic [7:0] alpha_pow(input int e);
    return 8'(exp_t[e % 255]);
  endfunction

  // S_j = r(alpha^(FCR+j)), first symbol of frm is the x^(N-1) coefficient.
  function automatic logic [SW-1:0] model_syn();
    logic [SW-1:0] v;
    logic [7:0]    s;
    v = '0;
    for (int jj = 0; jj < TWO_T; jj++) begin
      s = 8'h00;
      for (int i = 0; i < N; i++) s = s ^ gmul(frm[i], alpha_pow((FCR + jj) * (N - 1 - i)));
      v[8*jj +: 8] = s;
    end
    return v;
  endfunction

  function automatic logic [SW:0] model_exp();
    logic [SW-1:0] v;
    v = model_syn();
    return {1'(v == '0), v};
  endfunction

  task automatic random_frame();
    for (int i = 0; i < N; i++) frm[i] = 8'($urandom);
  endtask

  // Non-systematic codeword c(x) = m(x) * g(x), so every syndrome root divides it.
  task automatic build_codeword();
    logic [7:0] g[0:TWO_T];
    logic [7:0] m[0:N-TWO_T-1];
    logic [7:0] c[0:N-1];
    logic [7:0] r;
    g[0] = 8'h01;
    for (int k = 1; k <= TWO_T; k++) g[k] = 8'h00;
    for (int jj = 0; jj < TWO_T; jj++) begin
      r = alpha_pow(FCR + jj);
      for (int k = TWO_T; k > 0; k--) g[k] = g[k-1] ^ gmul(g[k], r);
      g[0] = gmul(g[0], r);
    end
    for (int d = 0; d < N - TWO_T; d++) m[d] = 8'($urandom);
    for (int d = 0; d < N; d++) c[d] = 8'h00;
    for (int d = 0; d < N - TWO_T; d++)
      for (int k = 0; k <= TWO_T; k++) c[d+k] = c[d+k] ^ gmul(m[d], g[k]);
    for (int i = 0; i < N; i++) frm[i] = c[N-1-i];
  endtask

  task automatic checkOutput(input string name, input logic [SW:0] act, input logic [SW:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  // Present one symbol (after optional random idle cycles) and wait until accepted.
  task automatic send(input logic [7:0] s, input logic sop, input int gap_pct);
    int guard;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_sym   = s;
    in_sop   = sop;
    guard    = 0;
    #1;
    while (!in_ready) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 1000) begin
        n_checks++;
        $display("[TB] FAIL accept_timeout: in_ready still %0b after %0d cycles, required 1", in_ready, guard);
        last_wait = guard;
        return;
      end
    end
    @(posedge clk);
    #1;
    last_wait = guard;
  endtask

  task automatic applyStimulus(input logic [SW:0] expv, input int gap_pct);
    exp_q.push_back(expv);
    for (int i = 0; i < N; i++) begin
      send(frm[i], i == 0, gap_pct);
      if (i == 0) begin
        first_wait = last_wait;
        first_err  = frame_err;
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    checkOutput("latency_syn_valid", (SW+1)'(syn_valid), (SW+1)'(1));
  endtask

  // Monitor: compare the held syndrome vector whenever a handshake is about to occur.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_seen++;
      if (syn_valid && syn_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_syn: got %h, expected no frame", syn_data);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("syndromes", {syn_zero, syn_data}, mon_exp);
        end
      end
    end
  end

  initial begin
    logic [SW:0] e;
    int          x;
    int          guard;

    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    exp_t[255] = 1;
    log_t[0]   = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", (SW+1)'(in_ready), (SW+1)'(1));
    checkOutput("reset_syn_valid", (SW+1)'(syn_valid), '0);
    checkOutput("reset_syn_out", {syn_zero, syn_data}, '0);
    checkOutput("reset_frame_err", (SW+1)'(frame_err), '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] zero codeword");
    for (int i = 0; i < N; i++) frm[i] = 8'h00;
    applyStimulus({1'b1, {SW{1'b0}}}, 0);
    checkOutput("first_no_err", (SW+1)'(first_err), '0);

    $display("[TB] single error at x^0");
    frm[N-1] = 8'h01;
    applyStimulus({1'b0, {TWO_T{8'h01}}}, 0);

    $display("[TB] single error at x^1");
    frm[N-1] = 8'h00;
    frm[N-2] = 8'h01;
    applyStimulus({1'b0, ALPHA_VEC}, 0);

    $display("[TB] valid codeword, then 3 symbol errors");
    build_codeword();
    applyStimulus({1'b1, {SW{1'b0}}}, 0);
    for (int k = 0; k < 3; k++) begin
      x = $urandom_range(N - 1);
      frm[x] = frm[x] ^ 8'($urandom_range(255, 1));
    end
    e = model_exp();
    applyStimulus(e, 0);
    applyStimulus(e, 30);

    $display("[TB] random frames with gaps");
    for (int f = 0; f < 2; f++) begin
      random_frame();
      applyStimulus(model_exp(), 25);
    end

    $display("[TB] backpressure and back-to-back");
    repeat (2) @(posedge clk);
    #1;
    syn_ready = 1'b0;
    random_frame();
    e = model_exp();
    applyStimulus(e, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_stable", {syn_zero, syn_data}, e);
      checkOutput("hold_ready_valid", (SW+1)'({in_ready, syn_valid}), (SW+1)'(2'b01));
    end
    random_frame();
    syn_ready = 1'b1;
    applyStimulus(model_exp(), 0);
    checkOutput("b2b_no_stall", (SW+1)'(first_wait), '0);

    $display("[TB] early SOP");
    repeat (2) @(posedge clk);
    #1;
    random_frame();
    for (int i = 0; i < 100; i++) send(frm[i], i == 0, 0);
    random_frame();
    applyStimulus(model_exp(), 0);
    err_exp++;
    checkOutput("early_sop_err", (SW+1)'(first_err), (SW+1)'(1));

    $display("[TB] symbol without SOP in IDLE");
    repeat (3) @(posedge clk);
    #1;
    send(8'h55, 1'b0, 0);
    in_valid = 1'b0;
    err_exp++;
    checkOutput("idle_nosop_err", (SW+1)'(frame_err), (SW+1)'(1));
    @(posedge clk);
    #1;
    checkOutput("idle_err_one_cycle", (SW+1)'({frame_err, syn_valid}), '0);

    $display("[TB] reset mid-frame");
    random_frame();
    for (int i = 0; i < 50; i++) send(frm[i], i == 0, 0);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_ctrl", (SW+1)'({in_ready, syn_valid, frame_err}), (SW+1)'(3'b100));
    checkOutput("midrst_syn", {syn_zero, syn_data}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    random_frame();
    applyStimulus(model_exp(), 20);

    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("queue_drained", (SW+1)'(exp_q.size()), '0);
    checkOutput("frame_err_count", (SW+1)'(err_seen), (SW+1)'(err_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
